// File: rtl/pixel_correct_lanes_pkg.sv
// pixel_correct_lanes_pkg: shared state/error encodings and a bit-count helper
package pixel_correct_lanes_pkg;
  typedef enum logic [2:0] {
    ST_STANDBY,
    ST_INTERFRAME,
    ST_INTERLINE,
    ST_INTRALINE,
    ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_UNDERRUN,
    ERR_LINE,
    ERR_ROW
  } err_t;

  function automatic logic [16:0] ones(input logic [31:0] v);
    ones = '0;
    for (int i = 0; i < 32; i++) ones += 17'(v[i]);
  endfunction
endpackage

// File: rtl/pixel_correct_lanes_lane.sv
// pixel_correct_lanes_lane: one lane's subtract/multiply/saturate pipe; PIXCOR_STATS_EN adds sat/clamp flags
module pixel_correct_lanes_lane
  import pixel_correct_lanes_pkg::*;
#(
  parameter int DN_SIZE   = 12,
  parameter int GAIN_SIZE = 16,
  parameter int GAIN_FRAC = 12,
  parameter int OUT_SIZE  = 16
) (
  input  logic                 pixel_clk,
  input  logic                 reset_n,
  input  logic [DN_SIZE-1:0]   dn,
  input  logic [DN_SIZE-1:0]   dark,
  input  logic [GAIN_SIZE-1:0] gain,
  output logic [OUT_SIZE-1:0]  pix
`ifdef PIXCOR_STATS_EN
  ,
  output logic                 sat,
  output logic                 clamp
`endif
);
  localparam int PW = DN_SIZE + GAIN_SIZE;
  localparam int QW = PW - GAIN_FRAC;

  logic [DN_SIZE:0]     diff;
  logic [DN_SIZE-1:0]   d_d, d_q;
  logic [GAIN_SIZE-1:0] g_d, g_q;
  logic [PW-1:0]        p_d, p_q;
  logic [QW-1:0]        q;
  logic                 over;
  logic [OUT_SIZE-1:0]  pix_d, pix_q;
`ifdef PIXCOR_STATS_EN
  logic [2:0] c_d, c_q;
  logic       s_d, s_q;
`endif

  // Saturation only exists when the shifted product is wider than the output
  if (QW > OUT_SIZE) begin : g_sat
    assign over = |q[QW-1:OUT_SIZE];
  end else begin : g_nosat
    assign over = 1'b0;
  end

  // S1 clamps negative differences, S2 multiplies, S3 truncates and saturates
  always_comb begin
    diff  = {1'b0, dn} - {1'b0, dark};
    d_d   = diff[DN_SIZE] ? '0 : diff[DN_SIZE-1:0];
    g_d   = gain;
    p_d   = PW'(d_q) * PW'(g_q);
    q     = p_q[PW-1:GAIN_FRAC];
    pix_d = over ? '1 : OUT_SIZE'(q);
`ifdef PIXCOR_STATS_EN
    c_d   = {c_q[1:0], diff[DN_SIZE]};
    s_d   = over;
`endif
  end

  // Pipeline registers; the clamp flag rides along so both flags line up with pix
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q   <= '0;
      g_q   <= '0;
      p_q   <= '0;
      pix_q <= '0;
`ifdef PIXCOR_STATS_EN
      c_q   <= '0;
      s_q   <= 1'b0;
`endif
    end else begin
      d_q   <= d_d;
      g_q   <= g_d;
      p_q   <= p_d;
      pix_q <= pix_d;
`ifdef PIXCOR_STATS_EN
      c_q   <= c_d;
      s_q   <= s_d;
`endif
    end
  end

  assign pix = pix_q;
`ifdef PIXCOR_STATS_EN
  assign sat   = s_q;
  assign clamp = c_q[2];
`endif
endmodule

// File: rtl/pixel_correct_lanes.sv
// pixel_correct_lanes: frame/line tracking FSM + N-lane dark/gain correction; PIXCOR_STATS_EN adds per-frame sat/clamp counters
module pixel_correct_lanes
  import pixel_correct_lanes_pkg::*;
#(
  parameter  int N_LANE       = 4,
  parameter  int DN_SIZE      = 12,
  parameter  int GAIN_SIZE    = 16,
  parameter  int GAIN_FRAC    = 12,
  parameter  int OUT_SIZE     = 16,
  parameter  int N_COL_MAX    = 2048,
  parameter  int N_ROW_MAX    = 2064,
  parameter  int N_FRAME_SIZE = 20,
  localparam int CW           = $clog2(N_COL_MAX + 1),
  localparam int RW           = $clog2(N_ROW_MAX + 1)
) (
  input  logic                          pixel_clk,
  input  logic                          reset_n,
  input  logic                          pix_valid,
  input  logic                          fval,
  input  logic                          lval,
  input  logic [N_LANE*DN_SIZE-1:0]     pix_dn,
  input  logic                          coeff_valid,
  input  logic [N_LANE*DN_SIZE-1:0]     coeff_dark,
  input  logic [N_LANE*GAIN_SIZE-1:0]   coeff_gain,
  output logic                          coeff_ack,
  output logic                          out_valid,
  output logic                          out_sol,
  output logic                          out_sof,
  output logic [N_LANE*OUT_SIZE-1:0]    out_pix,
  output logic [RW-1:0]                 n_row,
  output logic [CW-1:0]                 n_col,
  output logic [N_FRAME_SIZE-1:0]       n_frame,
  output logic                          error,
  output logic [1:0]                    err_code
`ifdef PIXCOR_STATS_EN
  ,
  output logic [15:0]                   sat_count,
  output logic [15:0]                   clamp_count
`endif
);
  state_t                  state_q, state_d;
  err_t                    code_q, code_d;
  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           col_q, col_d;
  logic [N_FRAME_SIZE-1:0] frame_q, frame_d;
  logic [2:0]              vld_q, vld_d, sol_q, sol_d, sof_q, sof_d;
  logic                    line_beat, run, row_ovr, col_ovr, frame_end;

  // Beat qualification, ack, marker shift and next-state logic
  always_comb begin
    line_beat = pix_valid && fval && lval;
    run       = state_q inside {ST_INTERFRAME, ST_INTERLINE, ST_INTRALINE};
    row_ovr   = state_q == ST_INTERLINE && row_q == RW'(N_ROW_MAX);
    col_ovr   = state_q == ST_INTRALINE && col_q == CW'(N_COL_MAX);
    frame_end = pix_valid && !fval && (state_q == ST_INTRALINE || state_q == ST_INTERLINE);
    coeff_ack = line_beat && run && coeff_valid && !row_ovr && !col_ovr;
    vld_d     = {vld_q[1:0], coeff_ack};
    sol_d     = {sol_q[1:0], coeff_ack && state_q != ST_INTRALINE};
    sof_d     = {sof_q[1:0], coeff_ack && state_q == ST_INTERFRAME};
    state_d   = state_q;
    code_d    = code_q;
    row_d     = row_q;
    col_d     = col_q;
    frame_d   = frame_q;
    case (state_q)
      ST_STANDBY:
        if (pix_valid && !fval) begin
          state_d = ST_INTERFRAME;
          row_d   = '0;
          col_d   = '0;
          frame_d = '0;
        end
      ST_INTERFRAME, ST_INTERLINE, ST_INTRALINE:
        if (line_beat && (row_ovr || col_ovr)) begin
          state_d = ST_ERROR;
          code_d  = row_ovr ? ERR_ROW : ERR_LINE;
        end else if (line_beat && !coeff_valid) begin
          state_d = ST_ERROR;
          code_d  = ERR_UNDERRUN;
        end else if (line_beat) begin
          state_d = ST_INTRALINE;
          row_d   = state_q == ST_INTERFRAME ? '0 : row_q;
          col_d   = (state_q == ST_INTRALINE ? col_q : '0) + CW'(N_LANE);
        end else if (frame_end) begin
          state_d = ST_INTERFRAME;
          frame_d = frame_q + N_FRAME_SIZE'(1);
        end else if (pix_valid && state_q == ST_INTRALINE) begin
          state_d = ST_INTERLINE;
          row_d   = row_q + RW'(1);
        end
      default: ;
    endcase
  end

  // FSM state, position counters and the sol/sof/valid marker pipe
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STANDBY;
      code_q  <= ERR_NONE;
      row_q   <= '0;
      col_q   <= '0;
      frame_q <= '0;
      vld_q   <= '0;
      sol_q   <= '0;
      sof_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      row_q   <= row_d;
      col_q   <= col_d;
      frame_q <= frame_d;
      vld_q   <= vld_d;
      sol_q   <= sol_d;
      sof_q   <= sof_d;
    end
  end

  assign out_valid = vld_q[2];
  assign out_sol   = sol_q[2];
  assign out_sof   = sof_q[2];
  assign n_row     = row_q;
  assign n_col     = col_q;
  assign n_frame   = frame_q;
  assign error     = state_q == ST_ERROR;
  assign err_code  = code_q;

`ifdef PIXCOR_STATS_EN
  logic [N_LANE-1:0] sat_l, clamp_l;
  logic [2:0]        eof_q, eof_d;
  logic [16:0]       sat_sum, clamp_sum;
  logic [15:0]       sat_acc_q, sat_acc_d, clamp_acc_q, clamp_acc_d;
  logic [15:0]       sat_cnt_q, sat_cnt_d, clamp_cnt_q, clamp_cnt_d;

  // Frame end is delayed through the pipe so the last beats of a frame count before the latch
  always_comb begin
    eof_d       = {eof_q[1:0], frame_end};
    sat_sum     = {1'b0, sat_acc_q} + (vld_q[2] ? ones(32'(sat_l)) : 17'd0);
    clamp_sum   = {1'b0, clamp_acc_q} + (vld_q[2] ? ones(32'(clamp_l)) : 17'd0);
    sat_acc_d   = eof_q[2] ? '0 : sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    clamp_acc_d = eof_q[2] ? '0 : clamp_sum[16] ? 16'hFFFF : clamp_sum[15:0];
    sat_cnt_d   = eof_q[2] ? sat_acc_q : sat_cnt_q;
    clamp_cnt_d = eof_q[2] ? clamp_acc_q : clamp_cnt_q;
  end

  // Per-frame accumulators and their latched copies
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      eof_q       <= '0;
      sat_acc_q   <= '0;
      clamp_acc_q <= '0;
      sat_cnt_q   <= '0;
      clamp_cnt_q <= '0;
    end else begin
      eof_q       <= eof_d;
      sat_acc_q   <= sat_acc_d;
      clamp_acc_q <= clamp_acc_d;
      sat_cnt_q   <= sat_cnt_d;
      clamp_cnt_q <= clamp_cnt_d;
    end
  end

  assign sat_count   = sat_cnt_q;
  assign clamp_count = clamp_cnt_q;
`endif

  for (genvar i = 0; i < N_LANE; i++) begin : g_lane
    pixel_correct_lanes_lane #(
      .DN_SIZE  (DN_SIZE),
      .GAIN_SIZE(GAIN_SIZE),
      .GAIN_FRAC(GAIN_FRAC),
      .OUT_SIZE (OUT_SIZE)
    ) u_lane (
      .pixel_clk(pixel_clk),
      .reset_n  (reset_n),
      .dn       (pix_dn[i*DN_SIZE+:DN_SIZE]),
      .dark     (coeff_dark[i*DN_SIZE+:DN_SIZE]),
      .gain     (coeff_gain[i*GAIN_SIZE+:GAIN_SIZE]),
      .pix      (out_pix[i*OUT_SIZE+:OUT_SIZE])
`ifdef PIXCOR_STATS_EN
      ,
      .sat      (sat_l[i]),
      .clamp    (clamp_l[i])
`endif
    );
  end
endmodule
